// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / multiply / branch hazard control with registered forwarding selects.
// Defining HAZ_PERF_CNT_EN adds saturating stall_cnt_o and flush_cnt_o counters.
module hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] id_rd_i,
  input  logic       id_reg_write_i,
  input  logic       id_mem_read_i,
  input  logic       id_mul_i,
  input  logic       ex_branch_taken_i,
  output logic       pc_stall_o,
  output logic       ifid_stall_o,
  output logic       ifid_flush_o,
  output logic       idex_bubble_o,
  output logic       idex_hold_o,
  output logic       exmem_bubble_o,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       busy_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
`endif
);
  typedef enum logic [1:0] {RUN, LD_STALL, MUL_WAIT} state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic             ex_we_q, ex_we_d, ex_ld_q, ex_ld_d, mem_we_q, mem_we_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic             hold, flush, load_use, issue;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic en);
    return (!en || rs == 5'd0) ? 2'b00 :
           (ex_we_q && ex_rd_q == rs) ? 2'b01 :
           (mem_we_q && mem_rd_q == rs) ? 2'b10 : 2'b00;
  endfunction

  // Flush is gated by reset so every control output is quiet while reset is asserted.
  always_comb begin
    hold           = state_q == MUL_WAIT;
    flush          = reset_i && ex_branch_taken_i && state_q == RUN;
    load_use       = !hold && !flush && id_valid_i && ex_ld_q && ex_we_q && ex_rd_q != 5'd0 &&
                     ((id_use_rs1_i && id_rs1_i == ex_rd_q) || (id_use_rs2_i && id_rs2_i == ex_rd_q));
    issue          = !hold && !flush && !load_use && id_valid_i;
    pc_stall_o     = hold || load_use;
    ifid_stall_o   = hold || load_use;
    ifid_flush_o   = flush;
    idex_bubble_o  = flush || load_use;
    idex_hold_o    = hold;
    exmem_bubble_o = hold;
    busy_o         = state_q != RUN;
    state_d        = hold ? (cnt_q == CNT_W'(1) ? RUN : MUL_WAIT) :
                     (issue && id_mul_i) ? MUL_WAIT : load_use ? LD_STALL : RUN;
    cnt_d          = hold ? cnt_q - CNT_W'(1) : (issue && id_mul_i) ? CNT_W'(MUL_LAT - 1) : '0;
    ex_rd_d        = hold ? ex_rd_q : issue ? id_rd_i : 5'd0;
    ex_we_d        = hold ? ex_we_q : issue && id_reg_write_i;
    ex_ld_d        = hold ? ex_ld_q : issue && id_mem_read_i;
    mem_rd_d       = ex_rd_q;
    mem_we_d       = ex_we_q && !hold;
    fwd_a_d        = hold ? fwd_a_q : issue ? fwd_sel(id_rs1_i, id_use_rs1_i) : 2'b00;
    fwd_b_d        = hold ? fwd_b_q : issue ? fwd_sel(id_rs2_i, id_use_rs2_i) : 2'b00;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      ex_rd_q  <= 5'd0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= 5'd0;
      mem_we_q <= 1'b0;
      fwd_a_q  <= 2'b00;
      fwd_b_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ex_rd_q  <= ex_rd_d;
      ex_we_q  <= ex_we_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= mem_rd_d;
      mem_we_q <= mem_we_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end

  assign fwd_a_o = fwd_a_q;
  assign fwd_b_o = fwd_b_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, pc_stall_o && stall_cnt_q != '1};
    flush_cnt_d = flush_cnt_q + {15'd0, ifid_flush_o && flush_cnt_q != '1};
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed hazard scenarios plus randomized traffic against an instruction-level model.
module tb_hazard_ctrl;
  localparam int LAT = 3;
  logic clk = 1'b0, reset_i = 1'b0;
  logic id_valid_i = 0, id_use_rs1_i = 0, id_use_rs2_i = 0, id_reg_write_i = 0;
  logic id_mem_read_i = 0, id_mul_i = 0, ex_branch_taken_i = 0;
  logic [4:0] id_rs1_i = 0, id_rs2_i = 0, id_rd_i = 0;
  logic pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, idex_hold_o, exmem_bubble_o, busy_o;
  logic [1:0] fwd_a_o, fwd_b_o;
  logic [6:0] ctl;
  int checks = 0, failures = 0;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
`endif

  hazard_ctrl #(.MUL_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .reset_i(reset_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i), .id_mul_i(id_mul_i),
    .ex_branch_taken_i(ex_branch_taken_i), .pc_stall_o(pc_stall_o), .ifid_stall_o(ifid_stall_o),
    .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o), .idex_hold_o(idex_hold_o),
    .exmem_bubble_o(exmem_bubble_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .busy_o(busy_o)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;
  assign ctl = {pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, idex_hold_o, exmem_bubble_o, busy_o};

  // Model: the instruction records sitting in EX and MEM, plus how many extra cycles a multiply still owns EX.
  typedef struct packed {logic we; logic ld; logic [4:0] rd;} ins_t;
  ins_t m_ex, m_mem;
  int mul_left;
  bit m_ld, e_fl, e_lu, e_issue;
  logic [1:0] m_fa, m_fb;
  logic [6:0] e_ctl;
  logic [31:0] m_sc;
  logic [15:0] m_fc;

  function automatic logic [1:0] fsel(input logic [4:0] rs, input logic u);
    if (!u || rs == 0) return 2'b00;
    if (m_ex.we && m_ex.rd == rs) return 2'b01;
    if (m_mem.we && m_mem.rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_reset();
    m_ex = '0; m_mem = '0; mul_left = 0; m_ld = 0; m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
  endfunction

  function automatic void model_eval();
    bit mul, dep;
    mul = mul_left > 0;
    e_fl = reset_i && ex_branch_taken_i && !mul && !m_ld;
    dep = id_valid_i && m_ex.ld && m_ex.we && m_ex.rd != 0 &&
          ((id_use_rs1_i && id_rs1_i == m_ex.rd) || (id_use_rs2_i && id_rs2_i == m_ex.rd));
    e_lu = reset_i && !mul && !e_fl && dep;
    e_issue = !mul && id_valid_i && !e_fl && !e_lu;
    e_ctl = {mul || e_lu, mul || e_lu, e_fl, e_fl || e_lu, mul, mul, mul || m_ld};
  endfunction

  function automatic void model_clock();
    if (!reset_i) begin model_reset(); return; end
    model_eval();
    if (e_ctl[6] && m_sc != '1) m_sc++;
    if (e_fl && m_fc != '1) m_fc++;
    if (mul_left > 0) begin
      mul_left--;
      m_mem = '0;
    end else begin
      m_fa = e_issue ? fsel(id_rs1_i, id_use_rs1_i) : 2'b00;
      m_fb = e_issue ? fsel(id_rs2_i, id_use_rs2_i) : 2'b00;
      m_mem = m_ex;
      m_ex = e_issue ? {id_reg_write_i, id_mem_read_i, id_rd_i} : '0;
      m_ld = e_lu;
      if (e_issue && id_mul_i) mul_left = LAT - 1;
    end
  endfunction

  task automatic drive(input logic v, input logic [4:0] rd, rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, we, ld, mul, br);
    id_valid_i = v; id_rd_i = rd; id_rs1_i = rs1; id_use_rs1_i = u1; id_rs2_i = rs2; id_use_rs2_i = u2;
    id_reg_write_i = we; id_mem_read_i = ld; id_mul_i = mul; ex_branch_taken_i = br;
    #1 model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
  endtask

  task automatic test_reset();
    model_reset();
    drive(1, 5'd3, 5'd3, 1, 5'd3, 1, 1, 1, 1, 1);
    checks++; if (ctl !== 7'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0); end
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0) begin failures++; $display("FAIL reset_fwd got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
    tick(); tick();
    reset_i = 1'b1;
    idle(2);
  endtask

  task automatic test_fwd_priority();
    idle(2);
    drive(1, 5'd5, 5'd1, 1, 5'd2, 1, 1, 0, 0, 0); tick();
    drive(1, 5'd5, 5'd3, 1, 5'd4, 1, 1, 0, 0, 0); tick();
    drive(1, 5'd7, 5'd5, 1, 5'd5, 1, 1, 0, 0, 0);
    checks++; if (ctl !== 7'b0) begin failures++; $display("FAIL fwd_nostall got=%b exp=%b", ctl, 7'b0); end
    tick();
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0101) begin failures++; $display("FAIL fwd_exmem got=%b exp=0101", {fwd_a_o, fwd_b_o}); end
    drive(1, 5'd5, 5'd1, 1, 5'd2, 1, 1, 0, 0, 0); tick();
    idle(1);
    drive(1, 5'd7, 5'd5, 1, 5'd5, 1, 1, 0, 0, 0); tick();
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b1010) begin failures++; $display("FAIL fwd_memwb got=%b exp=1010", {fwd_a_o, fwd_b_o}); end
  endtask

  task automatic test_load_use();
    idle(2);
    drive(1, 5'd3, 5'd2, 1, 5'd0, 0, 1, 1, 0, 0); tick();
    drive(1, 5'd4, 5'd3, 1, 5'd1, 1, 1, 0, 0, 0);
    checks++; if (ctl !== 7'b1101000) begin failures++; $display("FAIL lu_stall got=%b exp=1101000", ctl); end
    tick();
    checks++; if (ctl !== 7'b0000001) begin failures++; $display("FAIL lu_recheck got=%b exp=0000001", ctl); end
    tick();
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b1000) begin failures++; $display("FAIL lu_fwd got=%b exp=1000", {fwd_a_o, fwd_b_o}); end
  endtask

  task automatic test_x0_unused();
    idle(2);
    drive(1, 5'd0, 5'd1, 1, 5'd0, 0, 1, 1, 0, 0); tick();
    drive(1, 5'd1, 5'd0, 1, 5'd0, 1, 1, 0, 0, 0);
    checks++; if (ctl !== 7'b0) begin failures++; $display("FAIL x0_nostall got=%b exp=%b", ctl, 7'b0); end
    tick();
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0) begin failures++; $display("FAIL x0_fwd got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
    drive(1, 5'd2, 5'd1, 1, 5'd0, 0, 1, 1, 0, 0); tick();
    drive(1, 5'd2, 5'd2, 0, 5'd2, 0, 1, 0, 0, 0);
    checks++; if (ctl !== 7'b0) begin failures++; $display("FAIL unused_nostall got=%b exp=%b", ctl, 7'b0); end
    tick();
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0) begin failures++; $display("FAIL unused_fwd got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
  endtask

  task automatic test_mul();
    idle(2);
    drive(1, 5'd6, 5'd1, 1, 5'd2, 1, 1, 0, 1, 0);
    checks++; if (ctl !== 7'b0) begin failures++; $display("FAIL mul_issue got=%b exp=%b", ctl, 7'b0); end
    tick();
    for (int i = 0; i < LAT - 1; i++) begin
      drive(1, 5'd8, 5'd6, 1, 5'd6, 1, 1, 0, 0, i == 0);
      checks++; if (ctl !== 7'b1100111) begin failures++; $display("FAIL mul_wait%0d got=%b exp=1100111", i, ctl); end
      tick();
    end
    checks++; if (ctl !== 7'b0) begin failures++; $display("FAIL mul_done got=%b exp=%b", ctl, 7'b0); end
    tick();
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0101) begin failures++; $display("FAIL mul_fwd got=%b exp=0101", {fwd_a_o, fwd_b_o}); end
  endtask

  task automatic test_branch_vs_load_use();
    idle(2);
    drive(1, 5'd3, 5'd2, 1, 5'd0, 0, 1, 1, 0, 0); tick();
    drive(1, 5'd4, 5'd3, 1, 5'd1, 1, 1, 0, 0, 1);
    checks++; if (ctl !== 7'b0011000) begin failures++; $display("FAIL br_flush got=%b exp=0011000", ctl); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 7'b0) begin failures++; $display("FAIL br_run got=%b exp=%b", ctl, 7'b0); end
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0) begin failures++; $display("FAIL br_fwd got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
    tick();
  endtask

  task automatic test_reset_in_mul();
    idle(2);
    drive(1, 5'd6, 5'd1, 1, 5'd2, 1, 1, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (ctl !== 7'b1100111) begin failures++; $display("FAIL rmul_wait got=%b exp=1100111", ctl); end
    #2 reset_i = 1'b0;
    model_reset();
    #1;
    checks++; if (ctl !== 7'b0) begin failures++; $display("FAIL rmul_async got=%b exp=%b", ctl, 7'b0); end
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0) begin failures++; $display("FAIL rmul_fwd got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
    tick();
    reset_i = 1'b1;
`ifdef HAZ_PERF_CNT_EN
    checks++; if (stall_cnt_o !== 32'd0) begin failures++; $display("FAIL rmul_cnt got=%0d exp=0", stall_cnt_o); end
`endif
    drive(1, 5'd6, 5'd1, 1, 5'd2, 1, 1, 0, 1, 0); tick();
    for (int i = 0; i < LAT - 1; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (ctl !== 7'b1100111) begin failures++; $display("FAIL rmul_full%0d got=%b exp=1100111", i, ctl); end
      tick();
    end
    checks++; if (ctl !== 7'b0) begin failures++; $display("FAIL rmul_end got=%b exp=%b", ctl, 7'b0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(9) < 8, 5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)),
            5'($urandom_range(3)), 1'($urandom_range(1)), $urandom_range(4) != 0, $urandom_range(3) == 0,
            $urandom_range(7) == 0, $urandom_range(9) == 0);
      checks++; if (ctl !== e_ctl) begin failures++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", i, ctl, e_ctl); end
      tick();
      checks++;
      if ({fwd_a_o, fwd_b_o} !== {m_fa, m_fb}) begin
        failures++; $display("FAIL rnd_fwd cyc=%0d got=%b exp=%b", i, {fwd_a_o, fwd_b_o}, {m_fa, m_fb});
      end
    end
`ifdef HAZ_PERF_CNT_EN
    checks++; if (stall_cnt_o !== m_sc) begin failures++; $display("FAIL rnd_stall_cnt got=%0d exp=%0d", stall_cnt_o, m_sc); end
    checks++; if (flush_cnt_o !== m_fc) begin failures++; $display("FAIL rnd_flush_cnt got=%0d exp=%0d", flush_cnt_o, m_fc); end
`endif
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_x0_unused();
    test_mul();
    test_branch_vs_load_use();
    test_reset_in_mul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
